// File: rtl/alu_pkg.sv
// Shared definitions for the 16-bit integer ALU and its multiply sequencer
// (mul_ctrl), including opcode constants and the mul_ctrl state encoding.
package alu_pkg;

  localparam int WIDTH = 16;

  localparam logic [3:0] ALU_PASS_S = 4'b0000;
  localparam logic [3:0] ALU_PASS_R = 4'b0001;
  localparam logic [3:0] ALU_ADD    = 4'b0010;
  localparam logic [3:0] ALU_SUB    = 4'b0011;
  localparam logic [3:0] ALU_INC    = 4'b0100;
  localparam logic [3:0] ALU_DEC    = 4'b0101;
  localparam logic [3:0] ALU_SHL    = 4'b0110;
  localparam logic [3:0] ALU_SHR    = 4'b0111;
  localparam logic [3:0] ALU_AND    = 4'b1000;
  localparam logic [3:0] ALU_OR     = 4'b1001;
  localparam logic [3:0] ALU_XOR    = 4'b1010;
  localparam logic [3:0] ALU_NOT    = 4'b1011;
  localparam logic [3:0] ALU_NEG    = 4'b1100;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_NEG_A  = 3'd1,
    ST_NEG_B  = 3'd2,
    ST_MUL    = 3'd3,
    ST_NEG_LO = 3'd4,
    ST_NOT_HI = 3'd5,
    ST_INC_HI = 3'd6
  } mul_state_t;

endpackage

// File: rtl/mul_ctrl_if.sv
// Request/response and ALU-port bundle of mul_ctrl. Handshake: a request is
// taken on a rising edge where start=1 and ready=1; done pulses one cycle with prod valid.
interface mul_ctrl_if;
  import alu_pkg::*;

  logic               start;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic               signed_in;
  logic               ready;
  logic               done;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   alu_r;
  logic [WIDTH-1:0]   alu_s;
  logic [3:0]         alu_op;
  logic [WIDTH-1:0]   alu_y;
  logic               alu_c;
  logic               alu_z;
  mul_state_t         fsm_state;

  modport slave (
    input  start, a, b, signed_in, alu_y, alu_c, alu_z,
    output ready, done, prod, alu_r, alu_s, alu_op, fsm_state
  );

  modport master (
    output start, a, b, signed_in, alu_y, alu_c, alu_z,
    input  ready, done, prod, alu_r, alu_s, alu_op, fsm_state
  );
endinterface

// File: rtl/mul_ctrl.sv
// Shift-add 16x16->32 multiply sequencer driving an external shared ALU.
// Define SIGNED_MUL_EN to compile the two's-complement pre/post negation states.
module mul_ctrl
  import alu_pkg::*;
(
  input  logic      clk,
  input  logic      reset,
  mul_ctrl_if.slave bus
);

  mul_state_t         state, state_n;
  logic [WIDTH-1:0]   m, m_n, p, p_n, q, q_n;
  logic [3:0]         cnt, cnt_n;
  logic               neg, neg_n;
  logic               done_q, done_n;
  logic [2*WIDTH-1:0] prod_q, prod_n;
  logic [WIDTH:0]     sum;

`ifdef SIGNED_MUL_EN
  logic sgn, sgn_n;
  logic lz, lz_n;
`else
  logic unused_inputs;
  assign unused_inputs = bus.signed_in ^ bus.alu_z;
`endif

  // Carry only contributes on an add step; pass-R steps shift in zero.
  assign sum = {bus.alu_c & q[0], bus.alu_y};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= ST_IDLE;
      m      <= '0;
      p      <= '0;
      q      <= '0;
      cnt    <= '0;
      neg    <= 1'b0;
      done_q <= 1'b0;
      prod_q <= '0;
`ifdef SIGNED_MUL_EN
      sgn    <= 1'b0;
      lz     <= 1'b0;
`endif
    end else begin
      state  <= state_n;
      m      <= m_n;
      p      <= p_n;
      q      <= q_n;
      cnt    <= cnt_n;
      neg    <= neg_n;
      done_q <= done_n;
      prod_q <= prod_n;
`ifdef SIGNED_MUL_EN
      sgn    <= sgn_n;
      lz     <= lz_n;
`endif
    end
  end

  always_comb begin
    state_n    = state;
    m_n        = m;
    p_n        = p;
    q_n        = q;
    cnt_n      = cnt;
    neg_n      = neg;
    done_n     = 1'b0;
    prod_n     = prod_q;
    bus.alu_op = ALU_PASS_S;
    bus.alu_r  = '0;
    bus.alu_s  = '0;
`ifdef SIGNED_MUL_EN
    sgn_n      = sgn;
    lz_n       = lz;
`endif
    case (state)
      ST_IDLE: begin
        if (bus.start) begin
          m_n     = bus.a;
          q_n     = bus.b;
          p_n     = '0;
          cnt_n   = '0;
          neg_n   = 1'b0;
          state_n = ST_MUL;
`ifdef SIGNED_MUL_EN
          sgn_n   = bus.signed_in;
          if (bus.signed_in) state_n = ST_NEG_A;
`endif
        end
      end
      ST_MUL: begin
        bus.alu_r  = p;
        bus.alu_s  = m;
        bus.alu_op = q[0] ? ALU_ADD : ALU_PASS_R;
        p_n        = sum[WIDTH:1];
        q_n        = {sum[0], q[WIDTH-1:1]};
        cnt_n      = cnt + 4'd1;
        if (cnt == 4'd15) begin
`ifdef SIGNED_MUL_EN
          if (sgn) begin
            state_n = ST_NEG_LO;
          end else begin
            state_n = ST_IDLE;
            prod_n  = {p_n, q_n};
            done_n  = 1'b1;
          end
`else
          state_n = ST_IDLE;
          prod_n  = {p_n, q_n};
          done_n  = 1'b1;
`endif
        end
      end
`ifdef SIGNED_MUL_EN
      ST_NEG_A: begin
        bus.alu_op = ALU_NEG;
        bus.alu_s  = m;
        if (m[WIDTH-1]) begin
          m_n   = bus.alu_y;
          neg_n = ~neg;
        end
        state_n = ST_NEG_B;
      end
      ST_NEG_B: begin
        bus.alu_op = ALU_NEG;
        bus.alu_s  = q;
        if (q[WIDTH-1]) begin
          q_n   = bus.alu_y;
          neg_n = ~neg;
        end
        state_n = ST_MUL;
      end
      ST_NEG_LO: begin
        bus.alu_op = ALU_NEG;
        bus.alu_s  = q;
        if (neg) q_n = bus.alu_y;
        // A zero low half means the +1 of the 32-bit negate carries into P.
        lz_n    = bus.alu_z;
        state_n = ST_NOT_HI;
      end
      ST_NOT_HI: begin
        bus.alu_op = ALU_NOT;
        bus.alu_s  = p;
        if (neg) p_n = bus.alu_y;
        state_n = ST_INC_HI;
      end
      ST_INC_HI: begin
        bus.alu_op = (neg && lz) ? ALU_INC : ALU_PASS_S;
        bus.alu_s  = p;
        p_n        = bus.alu_y;
        prod_n     = {p_n, q};
        done_n     = 1'b1;
        state_n    = ST_IDLE;
      end
`endif
      default: state_n = ST_IDLE;
    endcase
  end

  assign bus.ready     = (state == ST_IDLE);
  assign bus.done      = done_q;
  assign bus.prod      = prod_q;
  assign bus.fsm_state = state;

endmodule

// File: tb/tb_mul_ctrl.sv
// Randomised scoreboard bench for mul_ctrl with a behavioural ALU and an
// arithmetic product/latency reference model.
module tb_mul_ctrl;
  import alu_pkg::*;

  logic clk;
  logic reset;
  int   cyc;
  int   checks;
  int   failures;
  logic b_zero_run;

  logic [31:0] exp_q[$];
  int          exp_cyc_q[$];

  mul_ctrl_if bus ();

  mul_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // external ALU model
  always_comb begin
    logic [16:0] t;
    t = '0;
    case (bus.alu_op)
      ALU_PASS_S: t = {1'b0, bus.alu_s};
      ALU_PASS_R: t = {1'b0, bus.alu_r};
      ALU_ADD:    t = {1'b0, bus.alu_r} + {1'b0, bus.alu_s};
      ALU_SUB:    t = {1'b0, bus.alu_r} - {1'b0, bus.alu_s};
      ALU_INC:    t = {1'b0, bus.alu_s} + 17'd1;
      ALU_DEC:    t = {1'b0, bus.alu_s} - 17'd1;
      ALU_SHL:    t = {bus.alu_s, 1'b0};
      ALU_SHR:    t = {1'b0, 1'b0, bus.alu_s[15:1]};
      ALU_AND:    t = {1'b0, bus.alu_r & bus.alu_s};
      ALU_OR:     t = {1'b0, bus.alu_r | bus.alu_s};
      ALU_XOR:    t = {1'b0, bus.alu_r ^ bus.alu_s};
      ALU_NOT:    t = {1'b0, ~bus.alu_s};
      ALU_NEG:    t = {1'b0, 16'd0 - bus.alu_s};
      default:    t = '0;
    endcase
    bus.alu_y = t[15:0];
    bus.alu_c = t[16];
    bus.alu_z = (t[15:0] == 16'd0);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // reference model: product and completion latency from the operation rules
  function automatic logic [31:0] ref_prod(input logic [15:0] x, input logic [15:0] y, input logic s);
    int sx, sy;
    logic [31:0] r;
    r = {16'd0, x} * {16'd0, y};
`ifdef SIGNED_MUL_EN
    if (s) begin
      sx = $signed(x);
      sy = $signed(y);
      r  = sx * sy;
    end
`else
    if (s) r = {16'd0, x} * {16'd0, y};
`endif
    return r;
  endfunction

  function automatic int ref_lat(input logic s);
`ifdef SIGNED_MUL_EN
    return s ? 21 : 16;
`else
    return s ? 16 : 16;
`endif
  endfunction

  // monitor / scoreboard
  always @(negedge clk) begin
    if (!reset) begin
      if (b_zero_run && !bus.ready) check("zero_b_no_add", {28'd0, bus.alu_op == ALU_ADD}, 32'd0);
      if (bus.done) begin
        if (exp_q.size() == 0) begin
          check("unexpected_done", 32'd1, 32'd0);
        end else begin
          check("prod", bus.prod, exp_q.pop_front());
          check("done_cycle", cyc, exp_cyc_q.pop_front());
          check("ready_with_done", {31'd0, bus.ready}, 32'd1);
        end
      end
    end
  end

  // driver
  task automatic do_op(input logic [15:0] x, input logic [15:0] y, input logic s,
                       input bit check_busy, input bit poke);
    int t, lat, acc;
    t = 0;
    @(negedge clk);
    while (!bus.ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!bus.ready) check("ready_timeout", 32'd0, 32'd1);
    bus.start     = 1'b1;
    bus.a         = x;
    bus.b         = y;
    bus.signed_in = s;
    @(posedge clk);
    #1;
    acc           = cyc;
    bus.start     = 1'b0;
    bus.a         = 16'($urandom);
    bus.b         = 16'($urandom);
    bus.signed_in = 1'($urandom);
    lat           = ref_lat(s);
    exp_q.push_back(ref_prod(x, y, s));
    exp_cyc_q.push_back(acc + lat);
    if (check_busy || poke) begin
      for (int i = 1; i <= lat; i++) begin
        @(negedge clk);
        if (check_busy) check("busy_ready_low", {31'd0, bus.ready}, 32'd0);
        if (poke && i == 5) begin
          bus.start = 1'b1;
          bus.a     = 16'($urandom);
          bus.b     = 16'($urandom);
        end
        if (poke && i == 6) bus.start = 1'b0;
      end
    end
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (exp_q.size() != 0) check("drain_timeout", exp_q.size(), 32'd0);
  endtask

  initial begin
    checks = 0;
    failures = 0;
    cyc = 0;
    b_zero_run = 1'b0;
    bus.start = 1'b0;
    bus.a = '0;
    bus.b = '0;
    bus.signed_in = 1'b0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_ready", {31'd0, bus.ready}, 32'd1);
    check("rst_done", {31'd0, bus.done}, 32'd0);
    check("rst_prod", bus.prod, 32'd0);
    check("rst_alu_op", {28'd0, bus.alu_op}, 32'd0);
    check("rst_alu_rs", {bus.alu_r, bus.alu_s}, 32'd0);
    reset = 1'b0;

    // directed unsigned cases
    do_op(16'd3, 16'd5, 1'b0, 1'b1, 1'b0);
    do_op(16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 1'b0);
    drain();
    b_zero_run = 1'b1;
    do_op(16'h1234, 16'h0000, 1'b0, 1'b0, 1'b0);
    drain();
    b_zero_run = 1'b0;
    do_op(16'h0000, 16'hBEEF, 1'b0, 1'b0, 1'b0);

    // signed directed cases
    do_op(16'hFFFD, 16'd5, 1'b1, 1'b1, 1'b0);
    do_op(16'h8000, 16'h8000, 1'b1, 1'b0, 1'b0);
    do_op(16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 1'b0);

    // start during operation is ignored
    do_op(16'h00A5, 16'h0133, 1'b0, 1'b0, 1'b1);
    do_op(16'h7FFF, 16'h8001, 1'b1, 1'b0, 1'b1);
    drain();

    // reset mid-operation abandons it
    do_op(16'h1111, 16'h2222, 1'b0, 1'b0, 1'b0);
    repeat (7) @(negedge clk);
    reset = 1'b1;
    #1;
    check("midrst_ready", {31'd0, bus.ready}, 32'd1);
    check("midrst_prod", bus.prod, 32'd0);
    check("midrst_alu_op", {28'd0, bus.alu_op}, 32'd0);
    check("midrst_done", {31'd0, bus.done}, 32'd0);
    exp_q.delete();
    exp_cyc_q.delete();
    @(negedge clk);
    reset = 1'b0;
    repeat (30) @(negedge clk);

    // randomised back-to-back traffic
    for (int i = 0; i < 40; i++) begin
      logic [15:0] x, y;
      x = 16'($urandom);
      y = 16'($urandom);
      case ($urandom_range(0, 5))
        0: x = 16'h8000;
        1: y = 16'hFFFF;
        2: y = 16'h0000;
        default: ;
      endcase
      do_op(x, y, 1'($urandom_range(0, 1)), 1'b0, ($urandom_range(0, 7) == 0));
    end
    drain();
    repeat (5) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
